// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order response buffer,
// and redirect flush with discard of stale in-flight responses.
module fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            misaligned
);

    localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    logic [XLEN-1:0] pc_q;
    logic [31:0]     buf_inst_q [BUF_DEPTH];
    logic [XLEN-1:0] buf_pc_q   [BUF_DEPTH];
    logic [XLEN-1:0] rq_pc_q    [BUF_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rq_wr_q, rq_rd_q;
    logic [CW-1:0]   count_q, out_q, drop_q;
    logic            misaligned_q;
    logic            req_fire, resp_drop, push, pop;

    always_comb begin
        imem_req_addr  = pc_q;
        // Credit: every outstanding request already owns a buffer slot.
        imem_req_valid = rst && !redirect_valid &&
                         ((32'(count_q) + 32'(out_q)) < BUF_DEPTH);
        req_fire       = imem_req_valid && imem_req_ready;
        resp_drop      = imem_resp_valid && (redirect_valid || (drop_q != '0));
        push           = imem_resp_valid && !resp_drop;
        inst_valid     = (count_q != '0);
        pop            = inst_valid && inst_ready && !redirect_valid;
        inst           = buf_inst_q[rd_ptr_q];
        inst_pc        = buf_pc_q[rd_ptr_q];
        misaligned     = misaligned_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rq_wr_q      <= '0;
            rq_rd_q      <= '0;
            count_q      <= '0;
            out_q        <= '0;
            drop_q       <= '0;
            misaligned_q <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_inst_q[i] <= '0;
                buf_pc_q[i]   <= '0;
                rq_pc_q[i]    <= '0;
            end
        end else begin
            misaligned_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            out_q        <= out_q + CW'(req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                pc_q     <= {redirect_pc[XLEN-1:2], 2'b00};
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                rq_wr_q  <= '0;
                rq_rd_q  <= '0;
                count_q  <= '0;
                // Everything still in flight is stale, including ones already marked.
                drop_q   <= out_q - CW'(imem_resp_valid);
            end else begin
                if (req_fire) begin
                    pc_q             <= pc_q + XLEN'(4);
                    rq_pc_q[rq_wr_q] <= pc_q;
                    rq_wr_q          <= rq_wr_q + AW'(1);
                end
                if (resp_drop) begin
                    drop_q <= drop_q - CW'(1);
                end
                if (push) begin
                    buf_inst_q[wr_ptr_q] <= imem_resp_data;
                    buf_pc_q[wr_ptr_q]   <= rq_pc_q[rq_rd_q];
                    wr_ptr_q             <= wr_ptr_q + AW'(1);
                    rq_rd_q              <= rq_rd_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model whose data
// encodes the fetch address, so each delivered word can be matched to its PC.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        misaligned;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .misaligned     (misaligned)
    );

    always #5 clk = ~clk;

    // Memory: response appears lat cycles after the accepting edge.
    int          lat = 1;
    logic        stage_v [8];
    logic [31:0] stage_a [8];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) stage_v[k] <= 1'b0;
        end else begin
            for (int k = 0; k < 7; k++) begin
                stage_v[k] <= stage_v[k+1];
                stage_a[k] <= stage_a[k+1];
            end
            stage_v[7] <= 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                stage_v[lat-1] <= 1'b1;
                stage_a[lat-1] <= imem_req_addr;
            end
        end
    end

    assign imem_resp_valid = stage_v[0];
    assign imem_resp_data  = {stage_a[0][24:0], 7'h13};

    int          nvec = 0, nerr = 0;
    int          nreq, ndel, cyc, first_valid;
    logic [31:0] exp_req, exp_inst;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at 1ns after a rising edge; samples each cycle 1ns later.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_req);
                exp_req += 32'd4;
                nreq++;
            end
            if (inst_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (inst_ready) begin
                    chk("inst_pc", inst_pc, exp_inst);
                    chk("inst", inst, {exp_inst[24:0], 7'h13});
                    chk("opcode", 32'(inst[6:0]), 32'h13);
                    exp_inst += 32'd4;
                    ndel++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic restart(input int l, input logic rdy_in);
        rst = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        lat = l;
        rst = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready = rdy_in;
        exp_req = 32'h0;
        exp_inst = 32'h0;
        nreq = 0;
        ndel = 0;
        cyc = 0;
        first_valid = -1;
    endtask

    initial begin
        rst = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        #3;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        @(posedge clk);
        #1;

        // Streaming with 1-cycle memory.
        restart(1, 1'b1);
        run(20);
        chk("first_valid_cycle", 32'(first_valid), 32'd2);
        chk("stream_requests", 32'(nreq), 32'd14);
        chk("stream_deliveries", 32'(ndel), 32'd12);

        // Decode stalled: credit stops fetching after two requests.
        restart(1, 1'b0);
        run(10);
        chk("stall_requests", 32'(nreq), 32'd2);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_inst_valid", 32'(inst_valid), 32'd1);
        chk("stall_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        ndel = 0;
        run(6);
        chk("drain_deliveries", 32'(ndel), 32'd4);

        // Fill the buffer, then reset mid-stream.
        inst_ready = 1'b0;
        run(6);
        chk("full_inst_valid", 32'(inst_valid), 32'd1);
        chk("full_req_valid", 32'(imem_req_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
        chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("midrst_req_addr", imem_req_addr, 32'h0);
        @(posedge clk);
        #1;
        restart(1, 1'b1);
        run(4);
        chk("postrst_requests", 32'(nreq), 32'd3);

        // 3-cycle memory, two in flight, redirect to 0x100.
        restart(3, 1'b1);
        run(2);
        chk("lat3_requests", 32'(nreq), 32'd2);
        chk("lat3_credit_stop", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("redir_no_req", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        chk("redir_aligned", 32'(misaligned), 32'd0);
        exp_req = 32'h100;
        exp_inst = 32'h100;
        ndel = 0;
        run(14);
        chk("redir_delivered", 32'(ndel != 0), 32'd1);

        // Misaligned redirect target.
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        chk("misaligned_pulse", 32'(misaligned), 32'd1);
        chk("misaligned_addr", imem_req_addr, 32'h100);
        @(posedge clk);
        #1;
        chk("misaligned_clear", 32'(misaligned), 32'd0);
        imem_req_ready = 1'b1;
        exp_req = 32'h100;
        exp_inst = 32'h100;
        ndel = 0;
        run(20);
        chk("misaligned_delivered", 32'(ndel != 0), 32'd1);

        // Redirect coincident with a response and a ready decode.
        restart(1, 1'b1);
        run(2);
        chk("coinc_inst_valid", 32'(inst_valid), 32'd1);
        chk("coinc_resp_present", 32'(imem_resp_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("coinc_no_req", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        chk("coinc_empty", 32'(inst_valid), 32'd0);
        exp_req = 32'h200;
        exp_inst = 32'h200;
        ndel = 0;
        run(10);
        chk("coinc_delivered", 32'(ndel != 0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
